// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer for the
// 512-byte, 64-bit data memory. Each transaction takes three cycles
// (grant, memory access, response), and only one is in flight at a time.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready offered to the selected requester; the grant latches
//        | the request and registers the memory strobes
// ACCESS | strobes are high; the memory samples at the closing edge
// RESP   | one-cycle response pulse to the granted requester

module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 512
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp1_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Highest start address whose 8-byte access still fits. The compare is
    // done on the full address width, so huge addresses never wrap into range.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              ptr;        // requester preferred when both are valid
    logic              lat_id;     // requester owning the transaction in flight
    logic              lat_write;
    logic              lat_err;

    logic              take0;
    logic              take1;
    logic              accept;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic              resp_any;
    logic [DATA_W-1:0] resp_data;

    // Grant selection: a lone valid requester wins outright, otherwise the
    // pointer decides. Nothing is offered while reset is held.
    always_comb begin
        take0 = 1'b0;
        take1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || !ptr)) begin
                take0 = 1'b1;
            end else if (req1_valid) begin
                take1 = 1'b1;
            end
        end
    end

    // Mux the granted request and range-check its address.
    always_comb begin
        accept       = take0 | take1;
        sel_write    = take1 ? req1_write : req0_write;
        sel_addr     = take1 ? req1_addr  : req0_addr;
        sel_wdata    = take1 ? req1_wdata : req0_wdata;
        sel_in_range = (sel_addr <= LAST_ADDR);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed three-cycle sequence once a grant is made.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch, round-robin pointer and registered memory port.
    // Reset clears the strobes immediately, which aborts an access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= 1'b0;
            lat_id         <= 1'b0;
            lat_write      <= 1'b0;
            lat_err        <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr            <= take0;
                        lat_id         <= take1;
                        lat_write      <= sel_write;
                        lat_err        <= !sel_in_range;
                        mem_address    <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_read       <= sel_in_range & !sel_write;
                        mem_write      <= sel_in_range & sel_write;
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Response routing: only the granted requester sees a pulse; load data is
    // forwarded only for an in-range load.
    always_comb begin
        resp_any    = (state == RESP);
        resp_data   = (!lat_write && !lat_err) ? mem_read_data : '0;
        req0_ready  = take0;
        req1_ready  = take1;
        resp0_valid = 1'b0;
        resp0_rdata = '0;
        resp0_err   = 1'b0;
        resp1_valid = 1'b0;
        resp1_rdata = '0;
        resp1_err   = 1'b0;
        if (resp_any && !lat_id) begin
            resp0_valid = 1'b1;
            resp0_rdata = resp_data;
            resp0_err   = lat_err;
        end
        if (resp_any && lat_id) begin
            resp1_valid = 1'b1;
            resp1_rdata = resp_data;
            resp1_err   = lat_err;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_write, req0_ready, resp0_valid, resp0_err;
    logic [63:0] req0_addr, req0_wdata, resp0_rdata;
    logic        req1_valid, req1_write, req1_ready, resp1_valid, resp1_err;
    logic [63:0] req1_addr, req1_wdata, resp1_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] tb_mem  [0:511];
    logic [7:0] ref_mem [0:511];
    bit         mem_inited = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(512)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
        .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
        .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Memory: registered one-cycle read, little-endian 8-byte accesses.
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= pat(i);
            mem_inited <= 1'b1;
        end else begin
            if (mem_write)
                for (int i = 0; i < 8; i++)
                    tb_mem[int'(mem_address[8:0]) + i] <= mem_write_data[8*i +: 8];
            if (mem_read)
                for (int i = 0; i < 8; i++)
                    mem_read_data[8*i +: 8] <= tb_mem[int'(mem_address[8:0]) + i];
        end
    end

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[int'(a[8:0]) + i];
        return w;
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) ref_mem[int'(a[8:0]) + i] = d[8*i +: 8];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drives one request from requester k and returns what was observed.
    // Starts and ends just after a rising edge with the DUT idle.
    task automatic xact(input int k, input logic w, input logic [63:0] a,
                        input logic [63:0] d, output int lat, output logic sr,
                        output logic sw, output logic [63:0] sa, output logic rv,
                        output logic [63:0] rd, output logic er, output logic orv);
        if (k == 0) begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end
        lat = 0;
        @(negedge clk);
        while (((k == 0) ? req0_ready : req1_ready) !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            lat++;
        end
        @(posedge clk); #1;
        if (k == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
        sr = mem_read; sw = mem_write; sa = mem_address;
        @(posedge clk); #1;
        @(negedge clk);
        rv  = (k == 0) ? resp0_valid : resp1_valid;
        rd  = (k == 0) ? resp0_rdata : resp1_rdata;
        er  = (k == 0) ? resp0_err   : resp1_err;
        orv = (k == 0) ? resp1_valid : resp0_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd8; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, mem_read, mem_write} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000", {req0_ready, req1_ready, mem_read, mem_write});
        end
        checks++;
        if ({resp0_valid, resp1_valid, resp0_err, resp1_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_resp got %b exp 0000", {resp0_valid, resp1_valid, resp0_err, resp1_err});
        end
        checks++;
        if (mem_address !== 64'd0 || mem_write_data !== 64'd0 || resp0_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h exp 0", mem_address, mem_write_data, resp0_rdata);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int lat; logic sr, sw, rv, er, orv; logic [63:0] sa, rd;
        xact(0, 1'b1, 64'd8, 64'h1122334455667788, lat, sr, sw, sa, rv, rd, er, orv);
        ref_write(64'd8, 64'h1122334455667788);
        checks++;
        if (lat !== 0 || sw !== 1'b1 || sr !== 1'b0 || sa !== 64'd8) begin
            errors++;
            $display("FAIL store_strobe got lat=%0d r=%b w=%b a=%h exp lat=0 r=0 w=1 a=8", lat, sr, sw, sa);
        end
        checks++;
        if (rv !== 1'b1 || rd !== 64'd0 || er !== 1'b0 || orv !== 1'b0) begin
            errors++;
            $display("FAIL store_resp got v=%b d=%h e=%b o=%b exp v=1 d=0 e=0 o=0", rv, rd, er, orv);
        end
        xact(0, 1'b0, 64'd8, 64'd0, lat, sr, sw, sa, rv, rd, er, orv);
        checks++;
        if (sr !== 1'b1 || sw !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe got r=%b w=%b exp r=1 w=0", sr, sw);
        end
        checks++;
        if (rv !== 1'b1 || rd !== 64'h1122334455667788 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_resp got v=%b d=%h e=%b exp v=1 d=1122334455667788 e=0", rv, rd, er);
        end
    endtask

    task automatic test_boundary();
        int lat; logic sr, sw, rv, er, orv; logic [63:0] sa, rd;
        xact(0, 1'b0, 64'd504, 64'd0, lat, sr, sw, sa, rv, rd, er, orv);
        checks++;
        if (sr !== 1'b1 || er !== 1'b0 || rv !== 1'b1 || rd !== word_at(64'd504)) begin
            errors++;
            $display("FAIL bound_504 got r=%b e=%b v=%b d=%h exp r=1 e=0 v=1 d=%h", sr, er, rv, rd, word_at(64'd504));
        end
        xact(0, 1'b0, 64'd505, 64'd0, lat, sr, sw, sa, rv, rd, er, orv);
        checks++;
        if (sr !== 1'b0 || sw !== 1'b0 || er !== 1'b1 || rv !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL bound_505 got r=%b w=%b e=%b v=%b d=%h exp 0 0 1 1 0", sr, sw, er, rv, rd);
        end
        xact(1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, lat, sr, sw, sa, rv, rd, er, orv);
        checks++;
        if (sr !== 1'b0 || er !== 1'b1 || rv !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL bound_wrap got r=%b e=%b v=%b d=%h exp 0 1 1 0", sr, er, rv, rd);
        end
        xact(1, 1'b1, 64'd600, 64'hA5A5, lat, sr, sw, sa, rv, rd, er, orv);
        checks++;
        if (sw !== 1'b0 || er !== 1'b1) begin
            errors++;
            $display("FAIL bound_store got w=%b e=%b exp w=0 e=1", sw, er);
        end
    endtask

    task automatic test_arbitration();
        int grants[$];
        int overlap = 0;
        int dual = 0;
        do_reset();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd256;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd264;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 && req1_ready === 1'b1) dual++;
            if (req0_ready === 1'b1) grants.push_back(0);
            if (req1_ready === 1'b1) grants.push_back(1);
            if (resp0_valid === 1'b1 && resp1_valid === 1'b1) overlap++;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (grants.size() !== 4 || dual !== 0 || overlap !== 0) begin
            errors++;
            $display("FAIL arb_count got grants=%0d dual=%0d overlap=%0d exp 4 0 0", grants.size(), dual, overlap);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] !== (i % 2)) begin
                    errors++;
                    $display("FAIL arb_order idx %0d got %0d exp %0d", i, grants[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_req1_only();
        int lat; logic sr, sw, rv, er, orv; logic [63:0] sa, rd;
        do_reset();
        xact(1, 1'b0, 64'd272, 64'd0, lat, sr, sw, sa, rv, rd, er, orv);
        checks++;
        if (lat !== 0 || rv !== 1'b1 || orv !== 1'b0 || rd !== word_at(64'd272)) begin
            errors++;
            $display("FAIL req1_only got lat=%0d v=%b o=%b d=%h exp 0 1 0 %h", lat, rv, orv, rd, word_at(64'd272));
        end
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd256;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd264;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL req1_then_both got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int resp_seen = 0;
        do_reset();
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 64'd16; req0_wdata = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant got %b exp 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_access got mem_write=%b exp 1", mem_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_address !== 64'd0) begin
            errors++;
            $display("FAIL mid_abort got w=%b a=%h exp w=0 a=0", mem_write, mem_address);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || mem_write !== 1'b0) resp_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (resp_seen !== 0) begin
            errors++;
            $display("FAIL mid_no_resp got %0d bad cycles exp 0", resp_seen);
        end
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd16;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd24;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_grant got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== word_at(64'd16)) begin
            errors++;
            $display("FAIL mid_mem_kept got v=%b d=%h exp v=1 d=%h", resp0_valid, resp0_rdata, word_at(64'd16));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_throughput();
        int rdy[$];
        int rsp[$];
        int bad_data = 0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd280;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready === 1'b1) rdy.push_back(c);
            if (resp0_valid === 1'b1) begin
                rsp.push_back(c);
                if (resp0_rdata !== word_at(64'd280)) bad_data++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        checks++;
        if (rdy.size() !== 4 || rsp.size() !== 4 || bad_data !== 0) begin
            errors++;
            $display("FAIL thru_count got ready=%0d resp=%0d bad=%0d exp 4 4 0", rdy.size(), rsp.size(), bad_data);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rdy[i] !== 3 * i || rsp[i] !== 3 * i + 2) begin
                    errors++;
                    $display("FAIL thru_spacing idx %0d got ready@%0d resp@%0d exp %0d %0d", i, rdy[i], rsp[i], 3 * i, 3 * i + 2);
                end
            end
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 64'(256 + $urandom_range(0, 248));
        if (r == 7) return 64'(505 + $urandom_range(0, 100));
        if (r == 8) return 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
        return {$urandom, $urandom};
    endfunction

    // Reference model: each requester either idles or holds one request;
    // a grant starts a three-cycle transaction (grant, access, response).
    task automatic test_random();
        logic        p_valid [2];
        logic        p_write [2];
        logic [63:0] p_addr  [2];
        logic [63:0] p_wdata [2];
        bit          busy    [2];
        int          phase = 0;
        int          prefer = 0;
        int          win;
        int          t_id = 0;
        logic        t_write = 1'b0;
        logic        t_inr = 1'b0;
        logic [63:0] t_addr = '0;
        logic [63:0] t_wdata = '0;
        logic [63:0] t_exp = '0;
        logic        ev0, ev1;
        for (int k = 0; k < 2; k++) begin
            p_valid[k] = 1'b0; p_write[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0; busy[k] = 1'b0;
        end
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_valid[k] && !busy[k] && $urandom_range(0, 3) == 0) begin
                    p_valid[k] = 1'b1;
                    p_write[k] = 1'($urandom_range(0, 1));
                    p_addr[k]  = rand_addr();
                    p_wdata[k] = {$urandom, $urandom};
                end
            end
            req0_valid = p_valid[0]; req0_write = p_write[0]; req0_wdata = p_wdata[0];
            req0_addr  = p_valid[0] ? p_addr[0] : {$urandom, $urandom};
            req1_valid = p_valid[1]; req1_write = p_write[1]; req1_wdata = p_wdata[1];
            req1_addr  = p_valid[1] ? p_addr[1] : {$urandom, $urandom};
            @(negedge clk);
            win = -1;
            if (phase == 0) begin
                if (p_valid[0] && (!p_valid[1] || prefer == 0)) win = 0;
                else if (p_valid[1]) win = 1;
            end
            checks++;
            if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d got %b%b exp %b%b", c, req0_ready, req1_ready, win == 0, win == 1);
            end
            checks++;
            if (mem_read !== (phase == 1 && t_inr && !t_write) || mem_write !== (phase == 1 && t_inr && t_write)) begin
                errors++;
                $display("FAIL rnd_strobe cyc %0d got r=%b w=%b exp r=%b w=%b", c, mem_read, mem_write,
                         phase == 1 && t_inr && !t_write, phase == 1 && t_inr && t_write);
            end
            if (phase == 1 && t_inr) begin
                checks++;
                if (mem_address !== t_addr || (t_write && mem_write_data !== t_wdata)) begin
                    errors++;
                    $display("FAIL rnd_mem_bus cyc %0d got a=%h d=%h exp a=%h d=%h", c, mem_address, mem_write_data, t_addr, t_wdata);
                end
            end
            ev0 = (phase == 2 && t_id == 0);
            ev1 = (phase == 2 && t_id == 1);
            checks++;
            if (resp0_valid !== ev0 || resp0_rdata !== (ev0 ? t_exp : 64'd0) || resp0_err !== (ev0 && !t_inr)) begin
                errors++;
                $display("FAIL rnd_resp0 cyc %0d got v=%b d=%h e=%b exp v=%b d=%h e=%b", c, resp0_valid, resp0_rdata,
                         resp0_err, ev0, ev0 ? t_exp : 64'd0, ev0 && !t_inr);
            end
            checks++;
            if (resp1_valid !== ev1 || resp1_rdata !== (ev1 ? t_exp : 64'd0) || resp1_err !== (ev1 && !t_inr)) begin
                errors++;
                $display("FAIL rnd_resp1 cyc %0d got v=%b d=%h e=%b exp v=%b d=%h e=%b", c, resp1_valid, resp1_rdata,
                         resp1_err, ev1, ev1 ? t_exp : 64'd0, ev1 && !t_inr);
            end
            if (phase == 2) begin
                busy[t_id] = 1'b0;
                phase = 0;
            end else if (phase == 1) begin
                phase = 2;
            end else if (win >= 0) begin
                t_id    = win;
                t_write = p_write[win];
                t_addr  = p_addr[win];
                t_wdata = p_wdata[win];
                t_inr   = (p_addr[win] <= 64'd504);
                t_exp   = (!t_write && t_inr) ? word_at(t_addr) : 64'd0;
                if (t_write && t_inr) ref_write(t_addr, t_wdata);
                p_valid[win] = 1'b0;
                busy[win] = 1'b1;
                prefer = 1 - win;
                phase = 1;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        test_reset();
        test_store_load();
        test_boundary();
        test_arbitration();
        test_req1_only();
        test_reset_mid();
        test_throughput();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
